// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers: per-channel one-cycle tick and ~50% square wave,
// with shadowed period writes applied at period boundaries and a global phase resync.
module clk_div_ch #(
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 250_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  output logic             pend,
  output logic             tick,
  output logic             sq
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CNT_W-1:0] phase, active, shadow;
  logic [CNT_W-1:0] nxt_phase, nxt_active, nxt_hi;
  logic             wrap, apply;

  // Outputs are decoded from next-state values so they line up with the registered phase.
  always_comb begin
    wrap       = (state == RUN) && en && (sync || phase == active - CNT_W'(1));
    apply      = pend && ((state == IDLE) || wrap);
    nxt_active = apply ? shadow : active;
    nxt_phase  = ((state == RUN) && en && !wrap) ? phase + CNT_W'(1) : '0;
    nxt_hi     = (nxt_active == CNT_W'(1)) ? CNT_W'(1) : nxt_active >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      active <= DEF;
      shadow <= DEF;
      pend   <= 1'b0;
      tick   <= 1'b0;
      sq     <= 1'b0;
    end else begin
      state  <= en ? RUN : IDLE;
      phase  <= nxt_phase;
      active <= nxt_active;
      if (wr) shadow <= div;
      // A write coinciding with an apply re-arms pend; the apply used the older shadow.
      pend   <= wr || (pend && !apply);
      tick   <= en && (nxt_phase == '0);
      sq     <= en && (nxt_phase < nxt_hi);
    end
  end
endmodule

module clk_div_bank #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 250_000,
  parameter int CH_W    = ($clog2(NCH) > 0) ? $clog2(NCH) : 1
) (
  input  logic             clk50MHz_i,
  input  logic             rst_n_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic [NCH-1:0]   pend_o,
  output logic             cfg_err_o,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   clk_o
);
  logic           cfg_ok;
  logic [NCH-1:0] wr;

  assign cfg_ok = (cfg_div_i != '0) && (32'(cfg_ch_i) < NCH);

  always_comb begin
    wr = '0;
    for (int k = 0; k < NCH; k++)
      wr[k] = cfg_we_i && cfg_ok && (32'(cfg_ch_i) == k);
  end

  always_ff @(posedge clk50MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) cfg_err_o <= 1'b0;
    else          cfg_err_o <= cfg_we_i && !cfg_ok;
  end

  clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch [NCH-1:0] (
    .clk   (clk50MHz_i),
    .rst_n (rst_n_i),
    .en    (en_i),
    .sync  ({NCH{sync_i}}),
    .wr    (wr),
    .div   ({NCH{cfg_div_i}}),
    .pend  (pend_o),
    .tick  (tick_o),
    .sq    (clk_o)
  );
endmodule
